// File: rtl/joybus_rx.sv
// Joybus response receiver: measures low-pulse widths on the open-drain line,
// decodes MSB-first bytes, and reports end of frame, no-response and framing errors.
module joybus_rx #(
  parameter int unsigned BIT_THRESH   = 100,
  parameter int unsigned MAX_LOW      = 250,
  parameter int unsigned IDLE_TIMEOUT = 250,
  parameter int unsigned RESP_TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       JB_RX,
  input  logic       rx_arm,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       rx_busy,
  output logic [5:0] rx_byte_cnt,
  output logic       rx_err,
  output logic       rx_timeout
);

  localparam logic [12:0] THRESH_C    = 13'(BIT_THRESH);
  localparam logic [12:0] LOW_LAST    = 13'(MAX_LOW - 1);
  localparam logic [12:0] IDLE_LAST   = 13'(IDLE_TIMEOUT - 1);
  localparam logic [12:0] RESP_LAST   = 13'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_LOW, S_HIGH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;

  logic rx_s, fall, rise, bit_in;

  assign rx_s   = sync_q[1];
  assign fall   = prev_q & ~rx_s;
  assign rise   = ~prev_q & rx_s;
  assign bit_in = (cnt_q < THRESH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], JB_RX};
      prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Timeout/error compares take priority over the line edge in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (rx_arm) state_d = S_WAIT_START;
      S_WAIT_START: if (cnt_q == RESP_LAST) state_d = S_IDLE;
                    else if (fall)         state_d = S_LOW;
      S_LOW:        if (cnt_q == LOW_LAST)  state_d = S_IDLE;
                    else if (rise)         state_d = S_HIGH;
      S_HIGH:       if (cnt_q == IDLE_LAST) state_d = S_IDLE;
                    else if (fall)         state_d = S_LOW;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      S_IDLE: if (rx_arm) begin
        err_d      = 1'b0;
        tmo_d      = 1'b0;
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      S_WAIT_START: if (cnt_q == RESP_LAST) begin
        tmo_d  = 1'b1;
        done_d = 1'b1;
      end
      S_LOW: begin
        if (cnt_q == LOW_LAST) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (rise) begin
          sh_d      = {sh_q[6:0], bit_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d  = {sh_q[6:0], bit_in};
            valid_d = 1'b1;
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 6'd1;
          end
        end
      end
      S_HIGH: if (cnt_q == IDLE_LAST) begin
        done_d = 1'b1;
        // bit_cnt of 1 is the device stop bit, dropped silently.
        if (bit_cnt_q > 3'd1) err_d = 1'b1;
      end
      default: ;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 13'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_done     = done_q;
  assign rx_busy     = (state_q != S_IDLE);
  assign rx_byte_cnt = byte_cnt_q;
  assign rx_err      = err_q;
  assign rx_timeout  = tmo_q;

endmodule

// File: doc/joybus_rx.md
# joybus_rx

Joybus response receiver, downstream of the Joybus command transmitter on the shared open-drain data line. Once armed (typically by the transmitter's `tx_done` pulse), it samples the line and measures each low pulse to decode pulse-width-coded bits MSB-first. It emits one byte strobe per 8 bits and signals end of frame on line-idle timeout. It also flags a missing response, a stuck-low line and a truncated frame.

## Interface
- `BIT_THRESH`, 100: low-phase length in clocks; a shorter low decodes as 1, otherwise 0. Nominal values are 50 for a 1 and 150 for a 0 at 50 MHz.
- `MAX_LOW`, 250: low-phase length in clocks at which the line is declared stuck low.
- `IDLE_TIMEOUT`, 250: high-phase length in clocks that ends the frame.
- `RESP_TIMEOUT`, 5000: clocks to wait for the first falling edge after arming.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `JB_RX`  in  1  raw Joybus line; asynchronous, idles high.
- `rx_arm`  in  1  single-cycle pulse that starts reception; ignored while `rx_busy`=1.
- `rx_data`  out  8  last completed byte; holds its value between strobes.
- `rx_valid`  out  1  single-cycle strobe; `rx_data` is new in this cycle.
- `rx_done`  out  1  single-cycle end-of-reception pulse, covering normal end, timeout and error.
- `rx_busy`  out  1  high in every state except IDLE.
- `rx_byte_cnt`  out  6  bytes received since the last arm; saturates at 63.
- `rx_err`  out  1  sticky framing/stuck-low flag; cleared by an accepted `rx_arm`.
- `rx_timeout`  out  1  sticky no-response flag; cleared by an accepted `rx_arm`.

## Operation
- `JB_RX` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`; the previous value is kept for edge detection.
- A falling edge is `rx_s`=0 with the previous value 1; a rising edge is the reverse.
- A single `cnt` counter (13 bits, wide enough for `RESP_TIMEOUT`) is cleared on every state change and increments otherwise.
- Other state: `bit_cnt` (3 bits), shift register `sh` (8 bits).
- States:
  - IDLE: outputs quiet. An `rx_arm` pulse clears `rx_err`, `rx_timeout`, `rx_byte_cnt`, `bit_cnt` and `cnt`, then moves to WAIT_START.
  - WAIT_START: a falling edge moves to LOW. A line that is already low on entry does not count as a start; only a falling edge does. If `cnt`==`RESP_TIMEOUT`-1 with no edge: set `rx_timeout`, pulse `rx_done`, go to IDLE.
  - LOW: `cnt` counts the low cycles. On a rising edge, shift the bit `cnt`<`BIT_THRESH` into `sh` LSB (so the first bit lands in the MSB after 8 shifts) and increment `bit_cnt`, then go to HIGH. When `bit_cnt` wraps from 7 to 0: load `rx_data` with the completed byte, pulse `rx_valid`, and increment `rx_byte_cnt` (saturating). If `cnt`==`MAX_LOW`-1 while still low: set `rx_err`, pulse `rx_done`, go to IDLE.
  - HIGH: a falling edge moves to LOW. If `cnt`==`IDLE_TIMEOUT`-1: end of frame, so pulse `rx_done` and go to IDLE, setting `rx_err` if `bit_cnt` is not 0 and not 1.
- Stop-bit handling: the device stop bit (about 2 µs low) is decoded as an ordinary bit, leaving `bit_cnt`=1. That leftover bit is discarded without a strobe.
- Zero bytes followed by only a stop bit (`rx_byte_cnt`=0, no error) is a legal empty response.
- Simultaneous events resolve in this priority: reset, then the timeout/error compare, then the edge.

## Timing
- Reset values: state IDLE, synchronizer 1, `rx_data`=0x00, all strobes and flags 0, `rx_byte_cnt`=0, `rx_busy`=0.
- Synchronizer latency from `JB_RX` to `rx_s` is 2 clocks.
- `rx_valid` and `rx_data` are registered. They update one clock after the cycle in which the rising edge ending the 8th bit's low phase is detected.
- `rx_done` is registered, with the same one-clock latency after the terminating condition.
  - On a timeout, `rx_timeout` is already 1 in the same cycle as `rx_done`.
  - On an error, `rx_err` is already 1 in the same cycle as `rx_done`.
- `rx_busy` rises the clock after an accepted `rx_arm` and falls in the same cycle that `rx_done` is high.
- Back-to-back operation: `rx_arm` is accepted in the cycle immediately after `rx_done`.
- Reset asserted mid-frame: return to IDLE on the next edge; no `rx_done` or `rx_valid` is emitted.

## Test plan
- Arm, then drive 0x05 with 50/150-clock lows in 200-clock bit cells plus a 100-clock stop low -> one `rx_valid` with `rx_data`=0x05, then `rx_done` 250 clocks after the last rising edge, `rx_byte_cnt`=1, `rx_err`=0.
- Arm, then send the 3-byte status 0x05 0x00 0x02 plus stop -> three `rx_valid` strobes in order, `rx_byte_cnt`=3, a single `rx_done`.
- Arm with the line held high -> `rx_done` and `rx_timeout`=1 exactly `RESP_TIMEOUT` clocks after entering WAIT_START; `rx_valid` never asserts.
- Arm, then hold the line low after the first falling edge -> `rx_err`=1 and `rx_done` after `MAX_LOW` low clocks.
- Arm, then send 4 bits and go idle -> no `rx_valid`, `rx_err`=1, `rx_byte_cnt`=0. Then re-arm and send 0xFF plus stop -> `rx_err` is cleared and `rx_data`=0xFF.
- Assert `rst` halfway through byte 2 of a 3-byte frame -> outputs return to reset values, no further strobes, and the next arm receives cleanly.
